// File: rtl/modulo_arbitro_transferencia_rolhas.sv
// Arbiter for the shared secondary cork buffer counter: operator reloads count up,
// automatic transfers to the main buffer count down, one cork per clock.
module modulo_arbitro_transferencia_rolhas #(
   parameter int unsigned WIDTH      = 7,
   parameter int unsigned LOTE       = 20,
   parameter int unsigned CAPACIDADE = 99
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             req_operador,
   input  logic [WIDTH-1:0] qtd_operador,
   input  logic             req_transfer,
   input  logic [WIDTH-1:0] nivel_secundario,
   output logic             en_contador,
   output logic             up_down,
   output logic             en_principal,
   output logic             ocupado,
   output logic             ack_operador,
   output logic             ack_transfer,
   output logic             erro_capacidade,
   output logic             falta_rolhas,
   output logic [2:0]       estado
);

   localparam int unsigned SUM_W = WIDTH + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      CARGA = 2'b01,
      CONTA = 2'b10,
      FIM   = 2'b11
   } state_t;

   state_t           state_q, state_d;
   logic             pend_op_q, pend_op_d;
   logic [WIDTH-1:0] qtd_lat_q, qtd_lat_d;
   logic [WIDTH-1:0] restante_q, restante_d;
   logic             dono_q, dono_d;
   logic             ultimo_q, ultimo_d;
   logic             up_down_d, en_contador_d, en_principal_d, ocupado_d;
   logic             ack_op_d, ack_tr_d, erro_d, falta_d;
   logic             transfer_ok;
   logic [SUM_W-1:0] soma;

   assign transfer_ok = req_transfer && (nivel_secundario >= WIDTH'(LOTE));
   // Widened sum so an oversized batch cannot wrap past the capacity check
   assign soma        = SUM_W'(nivel_secundario) + SUM_W'(qtd_lat_q);
   assign estado      = {dono_q, state_q};

   // Next-state and next-output logic
   always_comb begin
      state_d    = state_q;
      pend_op_d  = pend_op_q;
      qtd_lat_d  = qtd_lat_q;
      restante_d = restante_q;
      dono_d     = dono_q;
      ultimo_d   = ultimo_q;
      up_down_d  = up_down;
      ack_op_d   = 1'b0;
      ack_tr_d   = 1'b0;
      erro_d     = 1'b0;

      if (!pend_op_q && req_operador) begin
         pend_op_d = 1'b1;
         qtd_lat_d = qtd_operador;
      end

      unique case (state_q)
         IDLE: begin
            // Transfer wins unless it just ran and the operator is waiting
            if (transfer_ok && (!pend_op_q || !ultimo_q)) begin
               dono_d  = 1'b1;
               state_d = CARGA;
            end else if (pend_op_q) begin
               dono_d    = 1'b0;
               pend_op_d = 1'b0;
               state_d   = CARGA;
            end
         end
         CARGA: begin
            if (dono_q) begin
               restante_d = WIDTH'(LOTE);
               up_down_d  = 1'b0;
               state_d    = CONTA;
            end else if (soma > SUM_W'(CAPACIDADE)) begin
               erro_d  = 1'b1;
               state_d = IDLE;
            end else if (qtd_lat_q == '0) begin
               ack_op_d = 1'b1;
               state_d  = FIM;
            end else begin
               restante_d = qtd_lat_q;
               up_down_d  = 1'b1;
               state_d    = CONTA;
            end
         end
         CONTA: begin
            restante_d = restante_q - WIDTH'(1);
            if (restante_q == WIDTH'(1)) begin
               ack_op_d = ~dono_q;
               ack_tr_d = dono_q;
               state_d  = FIM;
            end
         end
         FIM: begin
            ultimo_d = dono_q;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase

      en_contador_d  = (state_d == CONTA);
      en_principal_d = en_contador_d & dono_d;
      ocupado_d      = (state_d != IDLE);
      falta_d        = req_transfer && (nivel_secundario < WIDTH'(LOTE));
   end

   // State and registered outputs
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q         <= IDLE;
         pend_op_q       <= 1'b0;
         qtd_lat_q       <= '0;
         restante_q      <= '0;
         dono_q          <= 1'b0;
         ultimo_q        <= 1'b0;
         up_down         <= 1'b0;
         en_contador     <= 1'b0;
         en_principal    <= 1'b0;
         ocupado         <= 1'b0;
         ack_operador    <= 1'b0;
         ack_transfer    <= 1'b0;
         erro_capacidade <= 1'b0;
         falta_rolhas    <= 1'b0;
      end else begin
         state_q         <= state_d;
         pend_op_q       <= pend_op_d;
         qtd_lat_q       <= qtd_lat_d;
         restante_q      <= restante_d;
         dono_q          <= dono_d;
         ultimo_q        <= ultimo_d;
         up_down         <= up_down_d;
         en_contador     <= en_contador_d;
         en_principal    <= en_principal_d;
         ocupado         <= ocupado_d;
         ack_operador    <= ack_op_d;
         ack_transfer    <= ack_tr_d;
         erro_capacidade <= erro_d;
         falta_rolhas    <= falta_d;
      end
   end

endmodule

// File: tb/tb_modulo_arbitro_transferencia_rolhas.sv
// Bench for the cork buffer arbiter: buffer-level model plus transaction-level expectations.
module tb_modulo_arbitro_transferencia_rolhas;

   logic       clk = 1'b0;
   logic       clr = 1'b1;
   logic       req_operador = 1'b0;
   logic [6:0] qtd_operador = '0;
   logic       req_transfer = 1'b0;
   logic [6:0] nivel_m = '0;
   logic       en_contador, up_down, en_principal, ocupado;
   logic       ack_operador, ack_transfer, erro_capacidade, falta_rolhas;
   logic [2:0] estado;

   int checks = 0;
   int failures = 0;

   int cyc = 0, up_steps = 0, down_steps = 0, prin_steps = 0;
   int ack_op_cnt = 0, ack_tr_cnt = 0, erro_cnt = 0, ack_op_cyc = 0, ack_n = 0;
   int ack_log [0:63];
   logic       load_en = 1'b0;
   logic [6:0] load_val = '0;

   modulo_arbitro_transferencia_rolhas dut (
      .clk(clk), .clr(clr),
      .req_operador(req_operador), .qtd_operador(qtd_operador),
      .req_transfer(req_transfer), .nivel_secundario(nivel_m),
      .en_contador(en_contador), .up_down(up_down), .en_principal(en_principal),
      .ocupado(ocupado), .ack_operador(ack_operador), .ack_transfer(ack_transfer),
      .erro_capacidade(erro_capacidade), .falta_rolhas(falta_rolhas), .estado(estado)
   );

   always #5 clk = ~clk;

   // Secondary buffer counter and step tallies
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (load_en) nivel_m <= load_val;
      else if (en_contador) nivel_m <= up_down ? nivel_m + 7'd1 : nivel_m - 7'd1;
      if (en_contador && up_down && !en_principal) up_steps <= up_steps + 1;
      if (en_contador && !up_down && en_principal) down_steps <= down_steps + 1;
      if (en_principal) prin_steps <= prin_steps + 1;
   end

   // Pulse monitor
   always @(negedge clk) begin
      if (ack_operador) begin
         ack_op_cnt <= ack_op_cnt + 1;
         ack_op_cyc <= cyc;
         ack_log[ack_n % 64] <= 0;
         ack_n <= ack_n + 1;
      end
      if (ack_transfer) begin
         ack_tr_cnt <= ack_tr_cnt + 1;
         ack_log[ack_n % 64] <= 1;
         ack_n <= ack_n + 1;
      end
      if (erro_capacidade) erro_cnt <= erro_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic set_nivel(input int v);
      @(negedge clk);
      load_val = 7'(v);
      load_en  = 1'b1;
      @(negedge clk);
      load_en  = 1'b0;
   endtask

   // Pulses a request; k is the clock edge that samples it
   task automatic op_request(input int q, output int k);
      @(negedge clk);
      req_operador = 1'b1;
      qtd_operador = 7'(q);
      k = cyc + 1;
      @(negedge clk);
      req_operador = 1'b0;
   endtask

   task automatic wait_acks(input int target, input string tag);
      for (int i = 0; i < 300 && ack_n < target; i++) @(negedge clk);
      check(tag, 32'(ack_n >= target), 32'd1);
   endtask

   // Operator batch outcome from the capacity rule
   task automatic run_op(input int nv, input int q, input string tag);
      int k, u0, a0, e0, exp_steps, exp_lvl;
      bit rej;
      set_nivel(nv);
      u0 = up_steps; a0 = ack_op_cnt; e0 = erro_cnt;
      rej = (nv + q) > 99;
      exp_steps = rej ? 0 : q;
      exp_lvl = nv + exp_steps;
      op_request(q, k);
      repeat (q + 8) @(negedge clk);
      check({tag, "_steps"}, 32'(up_steps - u0), 32'(exp_steps));
      check({tag, "_ack"}, 32'(ack_op_cnt - a0), rej ? 32'd0 : 32'd1);
      check({tag, "_erro"}, 32'(erro_cnt - e0), rej ? 32'd1 : 32'd0);
      check({tag, "_nivel"}, 32'(nivel_m), 32'(exp_lvl));
      if (!rej) check({tag, "_lat"}, 32'(ack_op_cyc), 32'(k + q + 2));
      check({tag, "_idle"}, 32'(ocupado), 32'd0);
   endtask

   // Transfer outcome: moves LOTE corks only when the level allows it
   task automatic run_tr(input int nv, input string tag);
      int d0, p0, t0, n0;
      set_nivel(nv);
      d0 = down_steps; p0 = prin_steps; t0 = ack_tr_cnt; n0 = ack_n;
      @(negedge clk);
      req_transfer = 1'b1;
      if (nv >= 20) begin
         repeat (3) @(negedge clk);
         check({tag, "_estado"}, 32'(estado), 32'd6);
         check({tag, "_falta"}, 32'(falta_rolhas), 32'd0);
         wait_acks(n0 + 1, {tag, "_done"});
         req_transfer = 1'b0;
      end else begin
         repeat (6) @(negedge clk);
         check({tag, "_falta"}, 32'(falta_rolhas), 32'd1);
         check({tag, "_ocup"}, 32'(ocupado), 32'd0);
         req_transfer = 1'b0;
      end
      repeat (4) @(negedge clk);
      check({tag, "_down"}, 32'(down_steps - d0), nv >= 20 ? 32'd20 : 32'd0);
      check({tag, "_prin"}, 32'(prin_steps - p0), nv >= 20 ? 32'd20 : 32'd0);
      check({tag, "_ack"}, 32'(ack_tr_cnt - t0), nv >= 20 ? 32'd1 : 32'd0);
      check({tag, "_nivel"}, 32'(nivel_m), nv >= 20 ? 32'(nv - 20) : 32'(nv));
   endtask

   initial begin
      int k, u0, d0, n0;
      int nv, q;

      #2 clr = 1'b0;
      #3;
      check("rst_estado", 32'(estado), 32'd0);
      check("rst_outs", 32'({en_contador, up_down, en_principal, ocupado, ack_operador,
                              ack_transfer, erro_capacidade, falta_rolhas}), 32'd0);
      repeat (2) @(negedge clk);
      clr = 1'b1;
      repeat (2) @(negedge clk);

      run_op(30, 15, "op15");
      check("op15_updown_hold", 32'(up_down), 32'd1);
      check("op15_prin", 32'(prin_steps), 32'd0);

      run_tr(50, "tr50");
      check("tr50_updown_hold", 32'(up_down), 32'd0);
      run_tr(19, "tr19");

      run_op(90, 10, "cap_rej");
      run_op(90, 9, "cap_ok");
      run_op(40, 0, "qtd0");

      // Contention: transfer -> operator -> transfer, second operator pulse ignored
      set_nivel(80);
      u0 = up_steps; d0 = down_steps; n0 = ack_n;
      @(negedge clk);
      req_transfer = 1'b1;
      repeat (3) @(negedge clk);
      op_request(5, k);
      repeat (3) @(negedge clk);
      op_request(7, k);
      wait_acks(n0 + 3, "cont_done");
      req_transfer = 1'b0;
      repeat (12) @(negedge clk);
      check("cont_order0", 32'(ack_log[n0 % 64]), 32'd1);
      check("cont_order1", 32'(ack_log[(n0 + 1) % 64]), 32'd0);
      check("cont_order2", 32'(ack_log[(n0 + 2) % 64]), 32'd1);
      check("cont_total", 32'(ack_n - n0), 32'd3);
      check("cont_up", 32'(up_steps - u0), 32'd5);
      check("cont_down", 32'(down_steps - d0), 32'd40);
      check("cont_nivel", 32'(nivel_m), 32'd45);
      check("cont_idle", 32'(ocupado), 32'd0);

      for (int i = 0; i < 8; i++) begin
         nv = $urandom_range(0, 99);
         q  = $urandom_range(0, 30);
         run_op(nv, q, $sformatf("rop%0d", i));
      end
      for (int i = 0; i < 4; i++) begin
         nv = $urandom_range(0, 99);
         run_tr(nv, $sformatf("rtr%0d", i));
      end

      // Reset in the middle of an operator batch of 10
      set_nivel(30);
      u0 = up_steps;
      op_request(10, k);
      repeat (6) @(negedge clk);
      check("mid_steps", 32'(up_steps - u0), 32'd4);
      clr = 1'b0;
      #1;
      check("mid_rst_estado", 32'(estado), 32'd0);
      check("mid_rst_outs", 32'({en_contador, up_down, en_principal, ocupado, ack_operador,
                                  ack_transfer, erro_capacidade, falta_rolhas}), 32'd0);
      @(negedge clk);
      clr = 1'b1;
      repeat (15) @(negedge clk);
      check("mid_total", 32'(up_steps - u0), 32'd4);
      check("mid_nivel", 32'(nivel_m), 32'd34);
      check("mid_idle", 32'(ocupado), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/modulo_arbitro_transferencia_rolhas.md
Name: modulo_arbitro_transferencia_rolhas

Overview:
- Arbitrates the shared 7-bit up/down secondary cork buffer counter between two requesters.
- Operator reload adds a batch of corks to the secondary buffer (count up).
- Automatic transfer moves a fixed batch from the secondary buffer to the main buffer (count down, one main-buffer increment per cork).
- Sits between the operator/min-cork request logic and the buffer counters; drives their enable, direction and increment strobes one cork per clock.

Parameters:
- WIDTH, 7, width of cork counts and buffer levels.
- LOTE, 20, corks moved per automatic transfer.
- CAPACIDADE, 99, maximum secondary buffer level.

Ports:
- clk  input  1  system clock (divided clock domain), rising edge.
- clr  input  1  asynchronous reset, active-low.
- req_operador  input  1  one-cycle pulse: operator reload request.
- qtd_operador  input  WIDTH  corks to add; sampled on the req_operador cycle.
- req_transfer  input  1  level: main buffer below minimum, transfer wanted.
- nivel_secundario  input  WIDTH  current secondary buffer level.
- en_contador  output  1  step enable for the shared secondary counter.
- up_down  output  1  1 = count up (operator), 0 = count down (transfer).
- en_principal  output  1  main buffer increment strobe.
- ocupado  output  1  arbiter not IDLE.
- ack_operador  output  1  one-cycle pulse: operator batch finished.
- ack_transfer  output  1  one-cycle pulse: transfer batch finished.
- erro_capacidade  output  1  one-cycle pulse: operator batch rejected.
- falta_rolhas  output  1  level: transfer wanted but secondary level < LOTE.
- estado  output  3  {dono, q1, q0}; dono: 0 = operator, 1 = transfer.

Behaviour:
- Reset (clr=0, async): state IDLE, pend_op=0, qtd_lat=0, restante=0, dono=0, ultimo_transfer=0, all outputs 0. A reset during CONTA drops the remaining count; already-stepped corks stay in the buffers.
- pend_op / qtd_lat:
  - If pend_op=0, req_operador sets pend_op=1 and latches qtd_operador into qtd_lat.
  - If pend_op=1, further requests are ignored, including one on the grant edge.
- FSM {q1,q0}: IDLE=00, CARGA=01, CONTA=10, FIM=11.
- IDLE grant, evaluated every clock:
  - Transfer eligible: req_transfer=1 and nivel_secundario ≥ LOTE.
  - If transfer eligible and (pend_op=0 or ultimo_transfer=0): grant transfer, dono=1.
  - Else if pend_op=1: grant operator, dono=0, pend_op cleared.
  - Any grant moves to CARGA.
- CARGA (1 cycle):
  - Transfer: restante=LOTE.
  - Operator, nivel_secundario + qtd_lat > CAPACIDADE: compare 8-bit, no wrap. Pulse erro_capacidade, go to IDLE, no counting.
  - Operator, qtd_lat=0: go straight to FIM.
  - Otherwise: restante=qtd_lat.
  - Any CARGA that does not go to IDLE or FIM goes to CONTA.
- CONTA:
  - en_contador=1 each cycle; restante decrements each cycle.
  - Last step is the cycle with restante=1; next state FIM.
  - up_down = ~dono. en_principal = en_contador & dono.
- FIM (1 cycle): pulse ack_operador or ack_transfer per dono; ultimo_transfer=dono; go to IDLE.
- Latency: operator pulse at edge k gives CARGA at k+1, N steps k+2..k+N+1, ack at k+N+2.
- ocupado = (state≠IDLE). up_down holds its last value outside CONTA; en_contador and en_principal are 0 outside CONTA.
- falta_rolhas is registered each clock as req_transfer & (nivel_secundario < LOTE), regardless of state.
- Anti-starvation: transfer has priority, but a pending operator request wins immediately after a completed transfer.

Test Plan:
- Reset mid-CONTA, operator batch 10 after 4 steps: clr=0 → all outputs 0 immediately, state 000. After release no further en_contador; exactly 4 up-steps total.
- Operator only, nivel=30, qtd=15: exactly 15 cycles en_contador=1 with up_down=1, en_principal=0. ack_operador 17 cycles after the request edge; counter ends at 45.
- Transfer, req_transfer=1, nivel=50: 20 cycles en_contador=1 with up_down=0 and en_principal=1. ack_transfer pulses; falta_rolhas=0. With nivel=19: no grant, falta_rolhas=1, ocupado=0.
- Capacity: nivel=90, qtd=10 → erro_capacidade pulses at CARGA, zero steps, no ack. qtd=9 → 9 steps, ack; level 99.
- qtd=0 → CARGA→FIM, ack_operador, zero steps.
- Contention: req_transfer held high, nivel=80, operator request qtd=5 during transfer. Order is transfer(20) → operator(5) → transfer(20). Second operator pulse during pending is ignored (only 5 corks added).
